instr_fetch_sequencer: RTL

- Front end of the autoencoder core: loads a program over a byte-serial valid/ready stream into internal instruction storage, then issues one 16-bit instruction per cycle to the CU/ALU/memory datapath.
- Replaces the free-running instruction counter with controlled start, hold, halt and completion.
- Instruction format is unchanged: [15:12] opcode, [11:8] field 1, [7:4] field 2, [3:0] field 3.

---
 rtl/instr_fetch_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: loads a program as a big-endian byte stream
// into local storage, then issues one 16-bit instruction per cycle with
// controlled start, hold, halt and completion.
module instr_fetch_sequencer #(
  parameter int         ADDR_W      = 8,
  parameter int         DEPTH       = 2**ADDR_W,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              byte_last,
  output logic              byte_ready,
  input  logic              run_start,
  input  logic              hold,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              done,
  output logic              load_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO, RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   load_ptr_q, load_ptr_d;
  logic [ADDR_W:0]     prog_len_q, prog_len_d;
  logic [15:0]         instr_q, instr_d;
  logic                vld_q, vld_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [7:0]          hi_q;
  logic                hi_we;
  logic                mem_we;
  logic [15:0]         mem [DEPTH];
  logic [ADDR_W:0]     fetch_addr;
  logic [15:0]         fetch_word;
  logic                hold_run;
  logic                term;

  // Hold only has meaning while a program is running.
  assign hold_run   = (state_q == RUN) && hold;
  // Once a word is live the next fetch is pc+1; on RUN entry it is pc itself.
  assign fetch_addr = vld_q ? ({1'b0, pc_q} + 1'b1) : {1'b0, pc_q};
  assign fetch_word = mem[fetch_addr[ADDR_W-1:0]];
  assign term       = (fetch_addr == prog_len_q) || (fetch_word[15:12] == HALT_OPCODE);

  // Next-state and register-update decode for the load/run controller.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    load_ptr_d = load_ptr_q;
    prog_len_d = prog_len_q;
    instr_d    = instr_q;
    vld_d      = vld_q;
    done_d     = 1'b0;
    err_d      = err_q;
    hi_we      = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = LOAD_HI;
          load_ptr_d = '0;
          prog_len_d = '0;
          err_d      = 1'b0;
        end else if (run_start) begin
          if (prog_len_q != '0) begin
            state_d = RUN;
            pc_d    = '0;
            vld_d   = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD_HI: begin
        if (byte_valid) begin
          if (byte_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            hi_we   = 1'b1;
            state_d = LOAD_LO;
          end
        end
      end
      LOAD_LO: begin
        if (byte_valid) begin
          mem_we     = 1'b1;
          prog_len_d = prog_len_q + 1'b1;
          if (byte_last) begin
            state_d = IDLE;
          end else if (load_ptr_q == LAST_ADDR) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            load_ptr_d = load_ptr_q + 1'b1;
            state_d    = LOAD_HI;
          end
        end
      end
      RUN: begin
        if (!hold) begin
          if (term) begin
            vld_d   = 1'b0;
            instr_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
            // A run ending past the last slot keeps pc on the last word.
            pc_d    = (fetch_addr == DEPTH_L) ? pc_q : fetch_addr[ADDR_W-1:0];
          end else begin
            vld_d   = 1'b1;
            instr_d = fetch_word;
            pc_d    = fetch_addr[ADDR_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      load_ptr_q <= '0;
      prog_len_q <= '0;
      instr_q    <= '0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      load_ptr_q <= load_ptr_d;
      prog_len_q <= prog_len_d;
      instr_q    <= instr_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Program storage and high-byte staging; contents survive reset.
  always_ff @(posedge clock) begin
    if (hi_we) begin
      hi_q <= byte_in;
    end
    if (mem_we) begin
      mem[load_ptr_q] <= {hi_q, byte_in};
    end
  end

  assign byte_ready  = (state_q == LOAD_HI) || (state_q == LOAD_LO);
  assign busy        = (state_q != IDLE);
  assign instr_valid = vld_q && !hold_run;
  assign instruction = instr_valid ? instr_q : 16'h0000;
  assign pc          = pc_q;
  assign prog_len    = prog_len_q;
  assign done        = done_q;
  assign load_err    = err_q;

endmodule
